zxnet_intrst_ctrl: RTL
======================

// Module: zxnet_intrst_ctrl
// PURPOSE
//  Parametrised interrupt and peripheral-reset controller for ZXiznet CPLD designs.
//  Successor to the fixed 2-source/2-reset #83AB logic.
//  Adds the following over that logic:
//   - NCH sources with per-source polarity and edge/level mode.
//   - W1C pending bits.
//   - NRST reset outputs with a guaranteed minimum low pulse.
//  Sits behind the Z80 port decoder; the decoder delivers synchronous strobes in the clk domain.
// PARAMETERS
//  NCH         2   interrupt sources, 1..8
//  NRST        2   peripheral reset outputs, 1..8
//  SYNC_STAGES 2   synchroniser flops per source, >=2
//  RST_MIN_CYC 16  minimum periph_rst_n low time in clk cycles, >=1
// PORTS
//  clk          in   1     system clock
//  rst_n        in   1     async active-low reset
//  wr_stb       in   1     1-cycle register write strobe
//  addr         in   3     register select
//  wr_data      in   8     write data
//  rd_data      out  8     read data, combinational from addr
//  irq_in       in   NCH   async interrupt lines from peripherals
//  int_n        out  1     ext. INT to Z80, active low, registered
//  int_any      out  1     internal interrupt (any pending & enabled), registered
//  periph_rst_n out  NRST  peripheral resets, active low, registered
// BEHAVIOUR
//  Clock and reset
//   - One clock. rst_n is asynchronous and active-low.
//   - On reset every register, counter and synchroniser is 0.
//   - Reset output values: int_n=1, int_any=0, periph_rst_n=0.
//  Registers (bits >=NCH / >=NRST read 0; unused addr reads 8'h00)
//   - 0 RAW   RO  synced irq_in after polarity: act[i] = sync[i] ^ POL[i].
//   - 1 PEND  R / W1C  pending bits.
//   - 2 ENA   RW  per-source enable.
//   - 3 MODE  RW  1=edge, 0=level.
//   - 4 POL   RW  1=active-low input.
//   - 5 CTRL  b6 eintena RW; b7 int_any RO.
//   - 6 RST   RW  bit=0 holds peripheral in reset, 1 releases.
//   - 7 RSTST RO  current periph_rst_n.
//  Source path
//   - irq_in passes SYNC_STAGES flops, then the POL xor gives act.
//   - act_d is act delayed by 1 clk.
//  Pending
//   - Level mode: PEND[i] = act[i], registered 1 clk; W1C has no effect.
//   - Edge mode: set on act & ~act_d; cleared by W1C with wr_data[i]=1.
//   - Edge mode, same-cycle set and clear: set wins.
//   - A MODE or POL write that changes bit i also clears PEND[i] and loads act_d[i]=act[i]. No spurious edge results.
//  Interrupt outputs
//   - int_any <= |(PEND & ENA) next clk.
//   - int_n   <= ~(eintena & |(PEND & ENA)), same clk as int_any.
//   - Latency irq_in edge -> int_n low: SYNC_STAGES+2 clk, for both modes.
//   - ENA or eintena writes affect int_n on the clk after wr_stb.
//  Reset pulse, per channel j
//   - Counter cnt[j] has width $clog2(RST_MIN_CYC+1).
//   - A write that makes RST[j] 0, or holds it at 0, clears cnt[j] on that clk.
//   - Otherwise cnt[j] increments, saturating at RST_MIN_CYC.
//   - periph_rst_n[j] <= RST[j] & (cnt[j]==RST_MIN_CYC).
//   - After a 0 write, a 1 written early keeps reset low until the counter saturates.
//   - Rewriting 0 mid-pulse restarts the count.
//   - Writing 1 to an already-released channel: no glitch.
//   - After rst_n deassert, RST=0, so all peripherals stay in reset until software releases them.
//  Reads
//   - No read side effects; rd_data is purely a mux.
//   - A write and a read of the same register in the same clk return the old value.
// TESTING
//  1. Release rst_n, no writes -> int_n=1, periph_rst_n=0, every reg reads 00 (RAW reflects irq_in).
//  2. Write RST=03 10 clk after reset, RST_MIN_CYC=16 -> periph_rst_n=00 until clk 17 after reset, then 11. RSTST then reads 03.
//  3. Write RST=01, RST=03 on next clk -> bit1 low exactly 17 clk after first write; bit0 stays 1, no glitch.
//  4. MODE=01, ENA=01, CTRL=40; pulse irq_in[0] high 1 clk-wide twice -> PEND=01; int_n low at SYNC_STAGES+2.
//     Then W1C 01 -> PEND=00, int_n=1 next clk.
//     Repeat with edge coincident with W1C -> PEND stays 01.
//  5. Level mode, POL=02, irq_in[1]=0 -> RAW=02, PEND=02.
//     ENA=02, CTRL=00 -> int_any=1, int_n=1. CTRL=40 -> int_n=0.
//  6. Random NCH=8 sweep: each cycle compare int_n against a reference model of the PEND/ENA/eintena equation; mismatch = fail.

Source files
------------

// File: rtl/zxnet_intrst_ctrl.sv
// Interrupt and peripheral-reset controller for ZXiznet CPLD designs.
// Handles synchronised, polarity-adjusted IRQ sources and reset outputs with a minimum low-pulse width.
module zxnet_intrst_ctrl #(
  parameter int NCH         = 2,
  parameter int NRST        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int RST_MIN_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_stb,
  input  logic [2:0]      addr,
  input  logic [7:0]      wr_data,
  output logic [7:0]      rd_data,
  input  logic [NCH-1:0]  irq_in,
  output logic            int_n,
  output logic            int_any,
  output logic [NRST-1:0] periph_rst_n
);

  localparam int CW = $clog2(RST_MIN_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RST_MIN_CYC);

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
  logic [NCH-1:0]  act_s, rise_s, w1c_s, cfg_chg_s;
  logic [NCH-1:0]  act_d_q, act_d_d, pend_q, pend_d;
  logic [NCH-1:0]  ena_q, ena_d, mode_q, mode_d, pol_q, pol_d;
  logic            eint_q, eint_d, int_any_q, int_any_d, int_n_q, int_n_d;
  logic [NRST-1:0] rst_q, rst_d, prst_q, prst_d;
  logic [NRST-1:0][CW-1:0] cnt_q, cnt_d;
  logic            wr_pend_s, wr_ena_s, wr_mode_s, wr_pol_s, wr_ctrl_s, wr_rst_s;
  logic            unused_wr_s;

  assign unused_wr_s = ^wr_data;
  assign act_s       = sync_q[SYNC_STAGES-1] ^ pol_q;

  // Next-state logic for sources, pending bits, interrupt outputs and reset pulses.
  always_comb begin
    wr_pend_s = wr_stb && (addr == 3'd1);
    wr_ena_s  = wr_stb && (addr == 3'd2);
    wr_mode_s = wr_stb && (addr == 3'd3);
    wr_pol_s  = wr_stb && (addr == 3'd4);
    wr_ctrl_s = wr_stb && (addr == 3'd5);
    wr_rst_s  = wr_stb && (addr == 3'd6);

    sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
    ena_d  = wr_ena_s  ? wr_data[NCH-1:0]  : ena_q;
    mode_d = wr_mode_s ? wr_data[NCH-1:0]  : mode_q;
    pol_d  = wr_pol_s  ? wr_data[NCH-1:0]  : pol_q;
    eint_d = wr_ctrl_s ? wr_data[6]        : eint_q;
    rst_d  = wr_rst_s  ? wr_data[NRST-1:0] : rst_q;

    // Using the new polarity here means a POL change never looks like an edge next cycle.
    act_d_d   = sync_q[SYNC_STAGES-1] ^ pol_d;
    cfg_chg_s = (mode_d ^ mode_q) | (pol_d ^ pol_q);
    rise_s    = act_s & ~act_d_q;
    w1c_s     = wr_pend_s ? wr_data[NCH-1:0] : '0;
    pend_d    = ((mode_q & ((pend_q & ~w1c_s) | rise_s)) | (~mode_q & act_s)) & ~cfg_chg_s;

    int_any_d = |(pend_q & ena_q);
    int_n_d   = ~(eint_q & int_any_d);

    for (int j = 0; j < NRST; j++) begin
      if (wr_rst_s && !wr_data[j]) begin
        cnt_d[j] = '0;
      end else if (cnt_q[j] != CNT_MAX) begin
        cnt_d[j] = cnt_q[j] + CW'(1);
      end else begin
        cnt_d[j] = cnt_q[j];
      end
      prst_d[j] = rst_q[j] && (cnt_q[j] == CNT_MAX);
    end
  end

  // State registers; every output is driven from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      act_d_q   <= '0;
      pend_q    <= '0;
      ena_q     <= '0;
      mode_q    <= '0;
      pol_q     <= '0;
      eint_q    <= 1'b0;
      int_any_q <= 1'b0;
      int_n_q   <= 1'b1;
      rst_q     <= '0;
      prst_q    <= '0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      act_d_q   <= act_d_d;
      pend_q    <= pend_d;
      ena_q     <= ena_d;
      mode_q    <= mode_d;
      pol_q     <= pol_d;
      eint_q    <= eint_d;
      int_any_q <= int_any_d;
      int_n_q   <= int_n_d;
      rst_q     <= rst_d;
      prst_q    <= prst_d;
      cnt_q     <= cnt_d;
    end
  end

  // Side-effect-free read mux; a same-cycle write is seen only after the edge.
  always_comb begin
    case (addr)
      3'd0:    rd_data = 8'(act_s);
      3'd1:    rd_data = 8'(pend_q);
      3'd2:    rd_data = 8'(ena_q);
      3'd3:    rd_data = 8'(mode_q);
      3'd4:    rd_data = 8'(pol_q);
      3'd5:    rd_data = {int_any_q, eint_q, 6'b000000};
      3'd6:    rd_data = 8'(rst_q);
      3'd7:    rd_data = 8'(prst_q);
      default: rd_data = 8'h00;
    endcase
  end

  assign int_n        = int_n_q;
  assign int_any      = int_any_q;
  assign periph_rst_n = prst_q;

endmodule
